// File: rtl/pwm_duty_meas.sv
// pwm_duty_meas: PWM receiver/decoder.
// Measures the period and high time of pwm_in in clk_100M cycles and reports
// both once per complete period. Flags a stuck line when no rising edge
// arrives within TIMEOUT cycles, and records the line level at that moment.
module pwm_duty_meas #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 60000
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_lvl
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             s_prev_q, s_prev_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stuck_q, stuck_d;
  logic             stuck_lvl_q, stuck_lvl_d;

  logic             s;
  logic             rise;
  logic [CNT_W-1:0] per_inc;
  logic [CNT_W-1:0] hi_inc;

  assign s       = sync2_q;
  assign rise    = s & ~s_prev_q;
  assign per_inc = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;
  assign hi_inc  = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CNT_ONE;

  // State register plus synchroniser, counters and registered outputs
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      s_prev_q     <= 1'b0;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      stuck_q      <= 1'b0;
      stuck_lvl_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      s_prev_q     <= s_prev_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      stuck_q      <= stuck_d;
      stuck_lvl_q  <= stuck_lvl_d;
    end
  end

  // Next state: a rise starts or continues measuring, a full timeout marks stuck
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = MEAS;
      MEAS:    if (!rise && (per_cnt_q == TMO)) state_d = STUCK;
      STUCK:   if (rise) state_d = MEAS;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs: counters, measurement capture and stuck flagging
  always_comb begin
    sync1_d      = pwm_in;
    sync2_d      = sync1_q;
    s_prev_d     = sync2_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    stuck_d      = stuck_q;
    stuck_lvl_d  = stuck_lvl_q;
    unique case (state_q)
      IDLE: begin
        per_cnt_d = rise ? CNT_ONE : '0;
        hi_cnt_d  = rise ? CNT_ONE : '0;
      end
      MEAS: begin
        if (rise) begin
          period_d     = per_cnt_q;
          high_d       = hi_cnt_q;
          meas_valid_d = 1'b1;
          per_cnt_d    = CNT_ONE;
          hi_cnt_d     = CNT_ONE;
        end else if (per_cnt_q == TMO) begin
          stuck_d     = 1'b1;
          stuck_lvl_d = s;
        end else begin
          per_cnt_d = per_inc;
          if (s) hi_cnt_d = hi_inc;
        end
      end
      STUCK: begin
        if (rise) begin
          stuck_d   = 1'b0;
          per_cnt_d = CNT_ONE;
          hi_cnt_d  = CNT_ONE;
        end
      end
      default: begin
        per_cnt_d = '0;
        hi_cnt_d  = '0;
      end
    endcase
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = meas_valid_q;
  assign stuck      = stuck_q;
  assign stuck_lvl  = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Testbench for pwm_duty_meas: a reference model derives expected measurements
// and stuck events from the rise times of the sampled input; a monitor compares
// them against the DUT outputs as they appear.
module tb_pwm_duty_meas;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned TIMEOUT = 1023;

  logic             clk_100M = 1'b0;
  logic             rst      = 1'b1;
  logic             pwm_in   = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_lvl;

  pwm_duty_meas #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .period_out (period_out),
    .high_out   (high_out),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .stuck_lvl  (stuck_lvl)
  );

  always #5 clk_100M = ~clk_100M;

  typedef struct { int cyc; int per; int hi; } meas_t;
  typedef struct { int cyc; bit stk; bit lvl; } stk_t;

  meas_t meas_q[$];
  stk_t  stk_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  // Reference model state: time of the last rise that opened a period and
  // the number of high samples seen since then.
  bit    hist[$];
  bit    m_prev, m_armed, m_stuck, m_lvl;
  int    m_last, m_ones;

  task automatic model_step(input bit v);
    bit rise;
    rise   = v && !m_prev;
    m_prev = v;
    if (rise) begin
      if (m_armed) meas_q.push_back(meas_t'{cyc, cyc - m_last, m_ones});
      if (m_stuck) stk_q.push_back(stk_t'{cyc, 1'b0, m_lvl});
      m_armed = 1'b1;
      m_stuck = 1'b0;
      m_last  = cyc;
      m_ones  = 0;
    end else if (m_armed && (cyc - m_last == int'(TIMEOUT))) begin
      m_stuck = 1'b1;
      m_lvl   = v;
      m_armed = 1'b0;
      stk_q.push_back(stk_t'{cyc, 1'b1, v});
    end
    if (m_armed && v) m_ones++;
  endtask

  // Model: each input sample takes effect on the outputs two cycles later
  always @(posedge clk_100M) begin
    cyc++;
    if (rst) begin
      if (m_stuck || m_lvl) stk_q.push_back(stk_t'{cyc, 1'b0, 1'b0});
      hist.delete();
      m_prev  = 1'b0;
      m_armed = 1'b0;
      m_stuck = 1'b0;
      m_lvl   = 1'b0;
      m_ones  = 0;
    end else begin
      hist.push_back(pwm_in);
      if (hist.size() == 3) model_step(hist.pop_front());
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops the expected event whenever the DUT presents one
  bit       mon_en    = 1'b0;
  logic [1:0] prev_pair = 2'b00;
  meas_t    em;
  stk_t     es;
  always @(negedge clk_100M) begin
    if (mon_en) begin
      if (meas_valid) begin
        n_cmp++;
        if (meas_q.size() == 0) begin
          n_bad++;
          $display("FAIL meas_unexpected: got pulse per=%0d hi=%0d at cycle %0d, required none",
                   period_out, high_out, cyc);
        end else begin
          em = meas_q.pop_front();
          if (em.cyc != cyc || em.per != int'(period_out) || em.hi != int'(high_out)) begin
            n_bad++;
            $display("FAIL meas: got cyc=%0d per=%0d hi=%0d, required cyc=%0d per=%0d hi=%0d",
                     cyc, period_out, high_out, em.cyc, em.per, em.hi);
          end
        end
      end
      if ({stuck, stuck_lvl} != prev_pair) begin
        n_cmp++;
        if (stk_q.size() == 0) begin
          n_bad++;
          $display("FAIL stuck_unexpected: got stuck=%0b lvl=%0b at cycle %0d, required no change",
                   stuck, stuck_lvl, cyc);
        end else begin
          es = stk_q.pop_front();
          if (es.cyc != cyc || es.stk != stuck || es.lvl != stuck_lvl) begin
            n_bad++;
            $display("FAIL stuck: got cyc=%0d stuck=%0b lvl=%0b, required cyc=%0d stuck=%0b lvl=%0b",
                     cyc, stuck, stuck_lvl, es.cyc, es.stk, es.lvl);
          end
        end
      end
      prev_pair = {stuck, stuck_lvl};
    end
  end

  task automatic pwm(input int per, input int hi, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < per; i++) begin
        pwm_in = (i < hi);
        @(negedge clk_100M);
      end
    end
  endtask

  task automatic hold(input bit v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk_100M);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, int'(period_out), 0);
    check({tag, "_high"},   int'(high_out),   0);
    check({tag, "_valid"},  int'(meas_valid), 0);
    check({tag, "_stuck"},  int'(stuck),      0);
    check({tag, "_lvl"},    int'(stuck_lvl),  0);
  endtask

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk_100M);
    check_zero("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    // Steady 10/3 waveform
    pwm(10, 3, 6);

    // Line held low: stuck with level 0, last measurement held
    hold(1'b0, TIMEOUT + 20);
    check("stuck_low", int'(stuck), 1);
    check("stuck_low_lvl", int'(stuck_lvl), 0);
    check("stuck_hold_period", int'(period_out), 10);
    check("stuck_hold_high", int'(high_out), 3);
    pwm(10, 3, 4);
    check("unstuck", int'(stuck), 0);

    // Line held high: stuck with level 1
    hold(1'b1, TIMEOUT + 20);
    check("stuck_high", int'(stuck), 1);
    check("stuck_high_lvl", int'(stuck_lvl), 1);
    hold(1'b0, 5);
    pwm(10, 3, 4);

    // Reset in the middle of a high phase
    pwm(10, 3, 3);
    pwm_in = 1'b1;
    repeat (2) @(negedge clk_100M);
    pwm_in = 1'b0;
    rst    = 1'b1;
    @(negedge clk_100M);
    rst    = 1'b0;
    check_zero("midreset");
    pwm(10, 3, 4);

    // Minimum period, a long period, the longest measurable and one past it
    pwm(2, 1, 30);
    pwm(250, 125, 3);
    pwm(int'(TIMEOUT), 500, 3);
    pwm(int'(TIMEOUT) + 1, 1, 2);
    pwm(10, 3, 3);

    // Random periods and duty cycles
    for (int k = 0; k < 40; k++) begin
      int p, h;
      p = int'($urandom_range(2, 60));
      h = int'($urandom_range(1, p - 1));
      pwm(p, h, 1);
    end

    // Random bit stream
    for (int k = 0; k < 400; k++) begin
      pwm_in = 1'($urandom_range(0, 1));
      @(negedge clk_100M);
    end

    hold(1'b0, 10);
    repeat (5) @(negedge clk_100M);
    check("meas_pending", meas_q.size(), 0);
    check("stuck_pending", stk_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
